// File: rtl/sakura_ctrl_pkg.sv
// Shared definitions for the control-FPGA host interface blocks.
// FSM encodings, default strobe timing and small sizing helpers.
package sakura_ctrl_pkg;

    typedef logic [1:0] rx_state_t;

    localparam rx_state_t IDLE    = 2'd0;
    localparam rx_state_t RD_LOW  = 2'd1;
    localparam rx_state_t RECOVER = 2'd2;

    localparam int DEF_RD_LOW_CYCLES  = 3;
    localparam int DEF_RD_HIGH_CYCLES = 4;

    function automatic int timer_bits(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for signals entering a clock domain.
// Width and reset value are parameters so inactive levels can be preset.
module sync_2ff #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/usb_rx_ctrl.sv
// Drains bytes from an FT245-style USB port into the host-to-board FIFO.
// Generates the RDn strobe timing, honours FIFO FULL and counts bytes.
module usb_rx_ctrl
    import sakura_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int RD_LOW_CYCLES  = DEF_RD_LOW_CYCLES,
    parameter int RD_HIGH_CYCLES = DEF_RD_HIGH_CYCLES,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                  WCLK,
    input  logic                  RSTn,
    input  logic                  ENABLE,
    input  logic                  USB_RXFn,
    input  logic [DATA_WIDTH-1:0] USB_D,
    output logic                  USB_RDn,
    output logic [DATA_WIDTH-1:0] FIFO_D,
    output logic                  FIFO_WE,
    input  logic                  FIFO_FULL,
    output logic                  BUSY,
    output logic [CNT_WIDTH-1:0]  RX_COUNT
);

    localparam int TW = timer_bits(RD_LOW_CYCLES, RD_HIGH_CYCLES);
    localparam logic [TW-1:0] LOW_LOAD  = TW'(RD_LOW_CYCLES - 1);
    localparam logic [TW-1:0] HIGH_LOAD = TW'(RD_HIGH_CYCLES - 1);

    rx_state_t             state;
    rx_state_t             state_nxt;
    logic [TW-1:0]         timer;
    logic [TW-1:0]         timer_nxt;
    logic                  rxf_s;
    logic                  timer_zero;
    logic                  start;
    logic                  rdn_nxt;
    logic                  we_nxt;
    logic [DATA_WIDTH-1:0] d_nxt;
    logic [CNT_WIDTH-1:0]  cnt_nxt;

    sync_2ff #(
        .WIDTH   (1),
        .RST_VAL (1'b1)
    ) u_rxf_sync (
        .clk   (WCLK),
        .rst_n (RSTn),
        .d     (USB_RXFn),
        .q     (rxf_s)
    );

    assign timer_zero = (timer == '0);
    // FULL is only consulted here, before a strobe begins
    assign start      = ENABLE && !rxf_s && !FIFO_FULL;
    assign BUSY       = (state != IDLE);

    always_ff @(posedge WCLK or negedge RSTn) begin
        if (!RSTn) begin
            state    <= IDLE;
            timer    <= '0;
            USB_RDn  <= 1'b1;
            FIFO_WE  <= 1'b0;
            FIFO_D   <= '0;
            RX_COUNT <= '0;
        end else begin
            state    <= state_nxt;
            timer    <= timer_nxt;
            USB_RDn  <= rdn_nxt;
            FIFO_WE  <= we_nxt;
            FIFO_D   <= d_nxt;
            RX_COUNT <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RD_LOW;
                    timer_nxt = LOW_LOAD;
                end
            end
            RD_LOW: begin
                if (timer_zero) begin
                    state_nxt = RECOVER;
                    timer_nxt = HIGH_LOAD;
                end else begin
                    timer_nxt = timer - TW'(1);
                end
            end
            RECOVER: begin
                if (timer_zero) begin
                    state_nxt = IDLE;
                end else begin
                    timer_nxt = timer - TW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                timer_nxt = '0;
            end
        endcase
    end

    // The byte is captured on the last low cycle, as RDn is released
    always_comb begin
        rdn_nxt = USB_RDn;
        we_nxt  = 1'b0;
        d_nxt   = FIFO_D;
        cnt_nxt = RX_COUNT;
        unique case (state)
            IDLE: begin
                rdn_nxt = !start;
            end
            RD_LOW: begin
                if (timer_zero) begin
                    rdn_nxt = 1'b1;
                    we_nxt  = 1'b1;
                    d_nxt   = USB_D;
                    cnt_nxt = RX_COUNT + CNT_WIDTH'(1);
                end
            end
            default: begin
                rdn_nxt = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_usb_rx_ctrl.sv
// Bench for usb_rx_ctrl: FTDI byte source, byte scoreboard and
// strobe-timing monitor around directed and randomized scenarios.
module tb_usb_rx_ctrl;

    logic       WCLK = 1'b0;
    logic       RSTn;
    logic       ENABLE;
    logic       USB_RXFn = 1'b1;
    logic [7:0] USB_D = 8'h00;
    logic       USB_RDn;
    logic [7:0] FIFO_D;
    logic       FIFO_WE;
    logic       FIFO_FULL;
    logic       BUSY;
    logic [3:0] RX_COUNT;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] ftdi_q[$];
    logic [7:0] exp_q[$];
    int         fall_q[$];
    int         cyc = 0;
    int         fall_cyc = 0;
    int         rise_cyc = 0;
    bit         have_rise = 0;
    bit         reading = 0;
    bit         prev_we = 0;
    int         model_cnt = 0;
    int         hold = 0;
    int         turn = 0;
    bit         rand_turn = 0;
    logic [7:0] exp_byte;

    usb_rx_ctrl #(
        .CNT_WIDTH (4)
    ) dut (
        .WCLK      (WCLK),
        .RSTn      (RSTn),
        .ENABLE    (ENABLE),
        .USB_RXFn  (USB_RXFn),
        .USB_D     (USB_D),
        .USB_RDn   (USB_RDn),
        .FIFO_D    (FIFO_D),
        .FIFO_WE   (FIFO_WE),
        .FIFO_FULL (FIFO_FULL),
        .BUSY      (BUSY),
        .RX_COUNT  (RX_COUNT)
    );

    always #5 WCLK = ~WCLK;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // FTDI device model plus scoreboard, evaluated once per cycle
    always @(negedge WCLK) begin
        cyc++;
        if (!RSTn) begin
            model_cnt = 0;
            have_rise = 0;
            if (reading && USB_RDn) begin
                reading = 0;
                if (exp_q.size() != 0) void'(exp_q.pop_back());
                if (ftdi_q.size() != 0) void'(ftdi_q.pop_front());
                USB_RXFn = 1'b1;
                hold = turn;
            end
        end else begin
            if (FIFO_WE) begin
                chk("we_one_cycle", 32'(prev_we), 32'd0);
                if (exp_q.size() == 0) begin
                    chk("we_unexpected", 32'd1, 32'd0);
                end else begin
                    exp_byte = exp_q.pop_front();
                    model_cnt++;
                    chk("fifo_d", 32'(FIFO_D), 32'(exp_byte));
                    chk("rx_count_track", 32'(RX_COUNT), model_cnt % 16);
                end
            end
            if (!reading && !USB_RDn) begin
                chk("strobe_gate", 32'({FIFO_FULL, ENABLE}), 32'd1);
                if (have_rise)
                    chk("rdn_high_gap", 32'((cyc - rise_cyc) >= 5), 32'd1);
                fall_q.push_back(cyc);
                fall_cyc = cyc;
                reading = 1;
                if (ftdi_q.size() == 0) begin
                    chk("ftdi_underrun", 32'd1, 32'd0);
                end else begin
                    USB_D = ftdi_q[0];
                    exp_q.push_back(ftdi_q[0]);
                end
            end else if (reading && USB_RDn) begin
                chk("rdn_low_width", cyc - fall_cyc, 32'd3);
                reading = 0;
                rise_cyc = cyc;
                have_rise = 1;
                if (ftdi_q.size() != 0) void'(ftdi_q.pop_front());
                USB_RXFn = 1'b1;
                if (rand_turn) turn = $urandom_range(0, 3);
                hold = turn;
            end
        end
        if (!reading && USB_RDn && USB_RXFn !== 1'b0 && hold > 0) begin
            hold--;
        end else if (!reading && USB_RDn && rise_cyc != cyc) begin
            USB_RXFn = (ftdi_q.size() == 0);
        end
        prev_we = FIFO_WE;
    end

    task automatic window(input int n, output int falls, output int wes,
                          output int busys);
        logic prev;
        prev = USB_RDn;
        falls = 0;
        wes = 0;
        busys = 0;
        repeat (n) begin
            @(negedge WCLK);
            #1;
            if (prev && !USB_RDn) falls++;
            prev = USB_RDn;
            if (FIFO_WE) wes++;
            if (BUSY) busys++;
        end
    endtask

    task automatic wait_strobe(input string tag);
        int n;
        n = 0;
        while (USB_RDn && n < 100) begin
            @(negedge WCLK);
            #1;
            n++;
        end
        chk(tag, 32'(USB_RDn), 32'd0);
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while ((ftdi_q.size() != 0 || BUSY || reading) && n < budget) begin
            @(negedge WCLK);
            #1;
            n++;
        end
        chk(tag, 32'(ftdi_q.size() == 0 && !BUSY), 32'd1);
    endtask

    initial begin
        int n;
        int f;
        int w;
        int b;
        RSTn = 1'b0;
        ENABLE = 1'b0;
        FIFO_FULL = 1'b0;
        repeat (3) @(negedge WCLK);
        #1;
        chk("rst_rdn", 32'(USB_RDn), 32'd1);
        chk("rst_we", 32'(FIFO_WE), 32'd0);
        chk("rst_fifo_d", 32'(FIFO_D), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_count", 32'(RX_COUNT), 32'd0);
        RSTn = 1'b1;
        ENABLE = 1'b1;
        repeat (2) @(negedge WCLK);
        #1;

        // single byte: latency, width, one write, busy length
        ftdi_q.push_back(8'hA5);
        @(negedge WCLK);
        #1;
        n = 0;
        do begin
            @(negedge WCLK);
            #1;
            n++;
        end while (USB_RDn && n < 20);
        chk("rdn_latency", n, 32'd3);
        window(12, f, w, b);
        chk("single_we", w, 32'd1);
        chk("single_busy_rest", b, 32'd6);
        chk("single_count", 32'(RX_COUNT), 32'd1);
        chk("single_data", 32'(FIFO_D), 32'hA5);

        // streaming 16 bytes with fastest RXFn turnaround
        fall_q.delete();
        for (int i = 0; i < 16; i++) ftdi_q.push_back(8'(i));
        drain("stream_drain", 400);
        chk("stream_strobes", fall_q.size(), 32'd16);
        for (int i = 1; i < fall_q.size(); i++)
            chk("stream_period", fall_q[i] - fall_q[i-1], 32'd8);
        chk("stream_count", 32'(RX_COUNT), 32'((1 + 16) % 16));

        // FULL back-pressure
        FIFO_FULL = 1'b1;
        ftdi_q.push_back(8'h5C);
        window(50, f, w, b);
        chk("full_no_strobe", f, 32'd0);
        chk("full_no_we", w, 32'd0);
        FIFO_FULL = 1'b0;
        @(negedge WCLK);
        #1;
        chk("full_release", 32'(USB_RDn), 32'd0);
        drain("full_drain", 50);

        // ENABLE drop during the second RD_LOW cycle
        ftdi_q.push_back(8'h3E);
        ftdi_q.push_back(8'hC1);
        wait_strobe("en_strobe");
        @(negedge WCLK);
        #1;
        ENABLE = 1'b0;
        window(15, f, w, b);
        chk("en_we", w, 32'd1);
        chk("en_no_strobe", f, 32'd0);
        chk("en_busy", 32'(BUSY), 32'd0);
        chk("en_rdn", 32'(USB_RDn), 32'd1);
        ENABLE = 1'b1;
        drain("en_drain", 50);

        // asynchronous reset in the middle of a strobe
        ftdi_q.push_back(8'h11);
        ftdi_q.push_back(8'h22);
        ftdi_q.push_back(8'h33);
        wait_strobe("rst_strobe");
        @(negedge WCLK);
        #1;
        RSTn = 1'b0;
        #1;
        chk("arst_rdn", 32'(USB_RDn), 32'd1);
        chk("arst_we", 32'(FIFO_WE), 32'd0);
        chk("arst_count", 32'(RX_COUNT), 32'd0);
        chk("arst_busy", 32'(BUSY), 32'd0);
        repeat (3) @(negedge WCLK);
        #1;
        RSTn = 1'b1;
        drain("arst_drain", 100);
        chk("arst_resume", 32'(RX_COUNT), 32'd2);
        chk("arst_last", 32'(FIFO_D), 32'h33);

        // counter wrap with a 4-bit counter
        RSTn = 1'b0;
        repeat (2) @(negedge WCLK);
        #1;
        RSTn = 1'b1;
        for (int i = 0; i < 17; i++) ftdi_q.push_back(8'(8'h30 + i));
        drain("wrap_drain", 400);
        chk("wrap_count", 32'(RX_COUNT), 32'd1);

        // randomized FULL/ENABLE/turnaround
        rand_turn = 1;
        for (int i = 0; i < 40; i++) ftdi_q.push_back(8'($urandom));
        for (int i = 0; i < 3000 && ftdi_q.size() != 0; i++) begin
            FIFO_FULL = ($urandom_range(0, 3) == 0);
            ENABLE = ($urandom_range(0, 7) != 0);
            @(negedge WCLK);
            #1;
        end
        FIFO_FULL = 1'b0;
        ENABLE = 1'b1;
        drain("rand_drain", 200);
        chk("rand_count", 32'(RX_COUNT), model_cnt % 16);
        chk("rand_scoreboard_empty", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
